// File: rtl/lcd_bus_receiver.sv
// Responder for a 4-bit HD44780-style write bus: synchronises the pins, rebuilds
// bytes from nibble pairs and keeps a 2x16 character image of the display.
module lcd_bus_receiver #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lcd_rs,
   input  logic         lcd_rw,
   input  logic         lcd_e,
   input  logic         lcd4,
   input  logic         lcd5,
   input  logic         lcd6,
   input  logic         lcd7,
   output logic [127:0] first_line,
   output logic [127:0] second_line,
   output logic [6:0]   cursor_addr,
   output logic         disp_on,
   output logic         byte_valid,
   output logic [7:0]   byte_out,
   output logic         byte_rs,
   output logic         proto_err
);

   typedef enum logic [1:0] {
      INIT8,
      NIB_HI,
      NIB_LO
   } mode_t;

   // Bus bit positions inside the synchronised vector.
   localparam int RS_BIT = 6;
   localparam int RW_BIT = 5;
   localparam int E_BIT  = 4;

   logic [6:0] pins;
   logic [6:0] sync_q [SYNC_STAGES];
   logic [6:0] prev_q;

   logic       edge_q;
   logic       edge_rs;
   logic       edge_rw;
   logic [3:0] edge_nib;
   logic       ev;

   mode_t      mode;
   mode_t      mode_next;
   logic       load_hi;
   logic       fire;
   logic       err;

   logic [3:0] hi_nib;
   logic       hi_rs;
   logic [7:0] new_byte;
   logic       dir_inc;

   logic [7:0] line1 [16];
   logic [7:0] line2 [16];

   assign pins = {lcd_rs, lcd_rw, lcd_e, lcd7, lcd6, lcd5, lcd4};

   // All bus bits travel through the same chain so rs/rw/data stay aligned with e.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         edge_q   <= 1'b0;
         edge_rs  <= 1'b0;
         edge_rw  <= 1'b0;
         edge_nib <= '0;
      end else begin
         edge_q   <= prev_q[E_BIT] & ~sync_q[SYNC_STAGES-1][E_BIT];
         edge_rs  <= prev_q[RS_BIT];
         edge_rw  <= prev_q[RW_BIT];
         edge_nib <= prev_q[3:0];
      end
   end

   // Read strobes are not supported and leave every piece of state untouched.
   assign ev       = edge_q & ~edge_rw;
   assign new_byte = {hi_nib, edge_nib};

   always_ff @(posedge clk) begin
      if (!rst_n) mode <= INIT8;
      else        mode <= mode_next;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      mode_next = mode;
      load_hi   = 1'b0;
      fire      = 1'b0;
      err       = 1'b0;
      if (ev) begin
         case (mode)
            INIT8: begin
               if (!edge_rs && edge_nib == 4'h3)      mode_next = INIT8;
               else if (!edge_rs && edge_nib == 4'h2) mode_next = NIB_HI;
               else                                   err       = 1'b1;
            end
            NIB_HI: begin
               load_hi   = 1'b1;
               mode_next = NIB_LO;
            end
            NIB_LO: begin
               mode_next = NIB_HI;
               if (edge_rs != hi_rs) err  = 1'b1;
               else                  fire = 1'b1;
            end
            default: mode_next = INIT8;
         endcase
      end
   end

   // Two-line DDRAM map: 0x00..0x27 and 0x40..0x67 chain into each other.
   function automatic logic [6:0] cursor_step(input logic [6:0] a, input logic up);
      logic [6:0] r;
      if (up) begin
         if (a == 7'h27)      r = 7'h40;
         else if (a == 7'h67) r = 7'h00;
         else                 r = a + 7'd1;
      end else begin
         if (a == 7'h40)      r = 7'h27;
         else if (a == 7'h00) r = 7'h67;
         else                 r = a - 7'd1;
      end
      return r;
   endfunction

   // NOTE: the character image is visible on the outputs, so it is reset like any register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            line1[i] <= BLANK_CHAR;
            line2[i] <= BLANK_CHAR;
         end
         cursor_addr <= '0;
         disp_on     <= 1'b0;
         dir_inc     <= 1'b1;
         byte_valid  <= 1'b0;
         proto_err   <= 1'b0;
         byte_out    <= '0;
         byte_rs     <= 1'b0;
         hi_nib      <= '0;
         hi_rs       <= 1'b0;
      end else begin
         byte_valid <= fire;
         proto_err  <= err;
         if (load_hi) begin
            hi_nib <= edge_nib;
            hi_rs  <= edge_rs;
         end
         if (fire) begin
            byte_out <= new_byte;
            byte_rs  <= edge_rs;
            if (edge_rs) begin
               if (cursor_addr[6:4] == 3'b000)      line1[cursor_addr[3:0]] <= new_byte;
               else if (cursor_addr[6:4] == 3'b100) line2[cursor_addr[3:0]] <= new_byte;
               cursor_addr <= cursor_step(cursor_addr, dir_inc);
            end else begin
               casez (new_byte)
                  8'b1???????: cursor_addr <= new_byte[6:0];
                  8'b00001???: disp_on     <= new_byte[2];
                  8'b000001??: dir_inc     <= new_byte[1];
                  8'b0000001?: cursor_addr <= '0;
                  8'b00000001: begin
                     for (int i = 0; i < 16; i++) begin
                        line1[i] <= BLANK_CHAR;
                        line2[i] <= BLANK_CHAR;
                     end
                     cursor_addr <= '0;
                     dir_inc     <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   for (genvar g = 0; g < 16; g++) begin : g_pack
      assign first_line[127-8*g -: 8]  = line1[g];
      assign second_line[127-8*g -: 8] = line2[g];
   end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives nibble transfers on the pins and
// compares the character image, cursor and pulses against hand-computed values.
module tb_lcd_bus_receiver;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
   logic         lcd4 = 1'b0, lcd5 = 1'b0, lcd6 = 1'b0, lcd7 = 1'b0;
   logic [127:0] first_line, second_line;
   logic [6:0]   cursor_addr;
   logic         disp_on, byte_valid, byte_rs, proto_err;
   logic [7:0]   byte_out;

   int total = 0;
   int bad   = 0;

   // Results of the most recent transfer.
   int           nv_cnt, nv_cyc, ne_cnt;
   int           bv_cnt, bv_cyc, be_cnt;
   logic [127:0] cap1, cap2;
   logic [6:0]   capc;
   logic [7:0]   capb;
   logic         caprs;

   localparam logic [127:0] BLANK = {16{8'h20}};

   always #5 clk = ~clk;

   lcd_bus_receiver #(.SYNC_STAGES(2), .BLANK_CHAR(8'h20)) dut (
      .clk(clk), .rst_n(rst_n),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd4(lcd4), .lcd5(lcd5), .lcd6(lcd6), .lcd7(lcd7),
      .first_line(first_line), .second_line(second_line),
      .cursor_addr(cursor_addr), .disp_on(disp_on),
      .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs),
      .proto_err(proto_err)
   );

   // One strobe; watches 7 cycles after the fall and records pulses and their cycle.
   task automatic nib(input logic rs, input logic rw, input logic [3:0] n);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; {lcd7, lcd6, lcd5, lcd4} = n;
      @(negedge clk);
      lcd_e = 1'b1;
      repeat (2) @(negedge clk);
      lcd_e = 1'b0;
      nv_cnt = 0; nv_cyc = 0; ne_cnt = 0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (byte_valid) begin
            nv_cnt++; nv_cyc = k;
            cap1 = first_line; cap2 = second_line; capc = cursor_addr;
            capb = byte_out; caprs = byte_rs;
         end
         if (proto_err) ne_cnt++;
      end
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] b);
      nib(rs, 1'b0, b[7:4]);
      bv_cnt = nv_cnt; be_cnt = ne_cnt;
      nib(rs, 1'b0, b[3:0]);
      bv_cnt += nv_cnt; be_cnt += ne_cnt; bv_cyc = nv_cyc;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (first_line !== BLANK) begin bad++; $display("FAIL reset_line1 got=%h exp=%h", first_line, BLANK); end
      total++; if (second_line !== BLANK) begin bad++; $display("FAIL reset_line2 got=%h exp=%h", second_line, BLANK); end
      total++; if (cursor_addr !== 7'h00 || disp_on !== 1'b0) begin bad++; $display("FAIL reset_cursor_disp got=%h/%b exp=00/0", cursor_addr, disp_on); end
      total++; if ({byte_valid, proto_err, byte_rs, byte_out} !== 11'd0) begin bad++; $display("FAIL reset_pulses got=%b%b%b %h exp=000 00", byte_valid, proto_err, byte_rs, byte_out); end
   endtask

   task automatic test_init();
      int v, e;
      logic [3:0] seq [4];
      seq = '{4'h3, 4'h3, 4'h3, 4'h2};
      v = 0; e = 0;
      for (int i = 0; i < 4; i++) begin
         nib(1'b0, 1'b0, seq[i]);
         v += nv_cnt; e += ne_cnt;
      end
      total++; if (v !== 0 || e !== 0) begin bad++; $display("FAIL init_pulses got valid=%0d err=%0d exp 0/0", v, e); end
      total++; if (first_line !== BLANK || second_line !== BLANK) begin bad++; $display("FAIL init_lines got=%h %h exp blank", first_line, second_line); end
   endtask

   task automatic test_write_line1();
      logic       rs_v [3];
      logic [7:0] b_v  [3];
      rs_v = '{1'b0, 1'b1, 1'b1};
      b_v  = '{8'h80, 8'h41, 8'h42};
      for (int i = 0; i < 3; i++) begin
         send_byte(rs_v[i], b_v[i]);
         total++; if (bv_cnt !== 1 || bv_cyc !== 4 || be_cnt !== 0) begin bad++; $display("FAIL line1_byte%0d got cnt=%0d cyc=%0d err=%0d exp 1/4/0", i, bv_cnt, bv_cyc, be_cnt); end
      end
      total++; if (capb !== 8'h42 || caprs !== 1'b1) begin bad++; $display("FAIL line1_byte_out got=%h/%b exp=42/1", capb, caprs); end
      total++; if (first_line[127:112] !== 16'h4142) begin bad++; $display("FAIL line1_chars got=%h exp=4142", first_line[127:112]); end
      total++; if (cursor_addr !== 7'h02) begin bad++; $display("FAIL line1_cursor got=%h exp=02", cursor_addr); end
   endtask

   task automatic test_line2_and_drop();
      send_byte(1'b0, 8'hC0);
      send_byte(1'b1, 8'h5A);
      total++; if (second_line[127:120] !== 8'h5A || cursor_addr !== 7'h41) begin bad++; $display("FAIL line2_write got=%h/%h exp=5a/41", second_line[127:120], cursor_addr); end
      send_byte(1'b0, 8'h8F);
      send_byte(1'b1, 8'h31);
      send_byte(1'b1, 8'h32);
      total++; if (first_line !== {8'h41, 8'h42, {13{8'h20}}, 8'h31}) begin bad++; $display("FAIL drop_line1 got=%h", first_line); end
      total++; if (second_line !== {8'h5A, {15{8'h20}}}) begin bad++; $display("FAIL drop_line2 got=%h", second_line); end
      total++; if (cursor_addr !== 7'h11) begin bad++; $display("FAIL drop_cursor got=%h exp=11", cursor_addr); end
   endtask

   task automatic test_cursor_map();
      send_byte(1'b0, 8'hA7);
      send_byte(1'b1, 8'h43);
      total++; if (cursor_addr !== 7'h40) begin bad++; $display("FAIL map_27_inc got=%h exp=40", cursor_addr); end
      send_byte(1'b0, 8'h04);
      send_byte(1'b1, 8'h44);
      total++; if (cursor_addr !== 7'h27) begin bad++; $display("FAIL map_40_dec got=%h exp=27", cursor_addr); end
      send_byte(1'b0, 8'h80);
      send_byte(1'b1, 8'h45);
      total++; if (cursor_addr !== 7'h67) begin bad++; $display("FAIL map_00_dec got=%h exp=67", cursor_addr); end
      send_byte(1'b0, 8'h06);
      send_byte(1'b0, 8'hFF);
      send_byte(1'b1, 8'h46);
      total++; if (cursor_addr !== 7'h00) begin bad++; $display("FAIL map_7f_inc got=%h exp=00", cursor_addr); end
      total++; if (first_line !== {8'h45, 8'h42, {13{8'h20}}, 8'h31} || second_line !== {8'h44, {15{8'h20}}}) begin bad++; $display("FAIL map_lines got=%h %h", first_line, second_line); end
   endtask

   task automatic test_proto_err();
      int v, e;
      nib(1'b1, 1'b0, 4'h4); v = nv_cnt; e = ne_cnt;
      nib(1'b0, 1'b0, 4'h1); v += nv_cnt; e += ne_cnt;
      total++; if (v !== 0 || e !== 1) begin bad++; $display("FAIL rs_mismatch got valid=%0d err=%0d exp 0/1", v, e); end
      total++; if (cursor_addr !== 7'h00 || first_line[127:120] !== 8'h45) begin bad++; $display("FAIL rs_mismatch_state got=%h/%h exp=00/45", cursor_addr, first_line[127:120]); end
      send_byte(1'b1, 8'h46);
      total++; if (bv_cnt !== 1 || first_line[127:120] !== 8'h46 || cursor_addr !== 7'h01) begin bad++; $display("FAIL after_err got cnt=%0d char=%h cur=%h exp 1/46/01", bv_cnt, first_line[127:120], cursor_addr); end
      nib(1'b0, 1'b1, 4'h8); v = nv_cnt; e = ne_cnt;
      nib(1'b1, 1'b1, 4'h3); v += nv_cnt; e += ne_cnt;
      lcd_rw = 1'b0;
      total++; if (v !== 0 || e !== 0 || cursor_addr !== 7'h01) begin bad++; $display("FAIL rw_ignored got valid=%0d err=%0d cur=%h exp 0/0/01", v, e, cursor_addr); end
      send_byte(1'b1, 8'h47);
      total++; if (bv_cnt !== 1 || be_cnt !== 0 || first_line[119:112] !== 8'h47 || cursor_addr !== 7'h02) begin bad++; $display("FAIL after_rw got cnt=%0d err=%0d char=%h cur=%h exp 1/0/47/02", bv_cnt, be_cnt, first_line[119:112], cursor_addr); end
   endtask

   task automatic test_clear();
      send_byte(1'b0, 8'hC5);
      send_byte(1'b1, 8'h5A);
      total++; if (second_line[87:80] !== 8'h5A) begin bad++; $display("FAIL fill_line2 got=%h exp=5a", second_line[87:80]); end
      send_byte(1'b0, 8'h04);
      send_byte(1'b0, 8'h01);
      total++; if (bv_cnt !== 1 || cap1 !== BLANK || cap2 !== BLANK || capc !== 7'h00) begin bad++; $display("FAIL clear_same_cycle got cnt=%0d cur=%h l1=%h l2=%h", bv_cnt, capc, cap1, cap2); end
      send_byte(1'b1, 8'h49);
      total++; if (first_line[127:120] !== 8'h49 || cursor_addr !== 7'h01) begin bad++; $display("FAIL clear_dir_inc got=%h/%h exp=49/01", first_line[127:120], cursor_addr); end
   endtask

   task automatic test_disp();
      send_byte(1'b0, 8'h08);
      total++; if (disp_on !== 1'b0) begin bad++; $display("FAIL disp_off got=%b exp=0", disp_on); end
      send_byte(1'b0, 8'h0C);
      total++; if (disp_on !== 1'b1) begin bad++; $display("FAIL disp_on got=%b exp=1", disp_on); end
   endtask

   task automatic test_reset_mid();
      int v, e;
      nib(1'b0, 1'b0, 4'h8);
      do_reset();
      total++; if (first_line !== BLANK || cursor_addr !== 7'h00 || disp_on !== 1'b0) begin bad++; $display("FAIL mid_reset_state got=%h/%b l1=%h", cursor_addr, disp_on, first_line); end
      send_byte(1'b0, 8'h80);
      total++; if (bv_cnt !== 0 || be_cnt !== 2) begin bad++; $display("FAIL mid_reset_init8 got valid=%0d err=%0d exp 0/2", bv_cnt, be_cnt); end
      nib(1'b0, 1'b0, 4'h3); v = nv_cnt; e = ne_cnt;
      nib(1'b0, 1'b0, 4'h2); v += nv_cnt; e += ne_cnt;
      total++; if (v !== 0 || e !== 0) begin bad++; $display("FAIL mid_reset_reinit got valid=%0d err=%0d exp 0/0", v, e); end
      send_byte(1'b1, 8'h48);
      total++; if (bv_cnt !== 1 || first_line[127:120] !== 8'h48 || cursor_addr !== 7'h01) begin bad++; $display("FAIL mid_reset_byte got cnt=%0d char=%h cur=%h exp 1/48/01", bv_cnt, first_line[127:120], cursor_addr); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_write_line1();
      test_line2_and_drop();
      test_cursor_map();
      test_proto_err();
      test_clear();
      test_disp();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Responder end of the HD44780-style 4-bit LCD write interface that our LCD driver produces on lcd_rs/lcd_rw/lcd_e/lcd4..lcd7.
- Synchronises the bus, detects lcd_e falling edges and reassembles nibbles into command/data bytes.
- Executes the display-relevant command subset and maintains a 2x16 character image exposed as two 128-bit line vectors.
- Used as an on-chip loopback checker and as the display model in driver benches.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on every bus input (minimum 2).
- BLANK_CHAR, 8'h20, fill value after reset and after Clear Display.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- lcd_rs  input  1  register select (0 = command, 1 = data)
- lcd_rw  input  1  read/write (1 = read; reads unsupported)
- lcd_e  input  1  enable strobe; transfer completes on falling edge
- lcd4, lcd5, lcd6, lcd7  input  1 each  data nibble, lcd7 = MSB
- first_line  output  128  chars 0..15 of line 1; char 0 in [127:120]
- second_line  output  128  chars 0..15 of line 2; same packing
- cursor_addr  output  7  current DDRAM address
- disp_on  output  1  display-on bit from last Display Control command
- byte_valid  output  1  one-cycle pulse per accepted byte
- byte_out  output  8  last accepted byte; valid while byte_valid is high
- byte_rs  output  1  rs of last accepted byte
- proto_err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (rst_n = 0 at posedge clk):
  - All chars = BLANK_CHAR; cursor_addr = 0; disp_on = 0.
  - byte_valid, proto_err, byte_out, byte_rs = 0.
  - Mode = INIT8, nibble phase = HI, entry direction = increment.
  - Synchroniser flops cleared to 0.
  - Reset mid-byte discards any held high nibble.
- Edge detect: falling edge = sync e was 1 in the previous cycle and is 0 now. rs, rw and the nibble are taken from the synchronised values of the previous cycle (last values while e was high).
- rw = 1 on an edge: ignored entirely. No state or phase change, no pulse.
- FSM:
  - INIT8: each edge carries one nibble, treated as the upper half of the bus.
    - rs = 0, nibble 4'h3: stay in INIT8.
    - rs = 0, nibble 4'h2: go to NIB_HI.
    - Anything else: proto_err pulse, stay in INIT8.
    - No byte_valid is produced in INIT8.
  - NIB_HI: store nibble and rs, go to NIB_LO.
  - NIB_LO: byte = {high, low}.
    - If rs differs from the stored rs: proto_err pulse, byte dropped, go to NIB_HI.
    - Otherwise: byte_valid pulse with byte_out/byte_rs, execute, go to NIB_HI.
- Latency: byte_valid and all buffer/cursor updates take effect in the cycle after the edge is detected. With SYNC_STAGES = 2 that is 4 clk after lcd_e falls at the pins.
- Command decode (rs = 0, priority MSB-first):
  - 1aaaaaaa: cursor_addr = aaaaaaa.
  - 01xxxxxx: CGRAM set, ignored.
  - 001xxxxx: Function Set, ignored. DL = 1 does not leave 4-bit mode.
  - 0001xxxx: shift, ignored.
  - 00001dxx: disp_on = d.
  - 000001ix: direction = i (1 = increment).
  - 0000001x: cursor_addr = 0.
  - 00000001: all 32 chars = BLANK_CHAR and cursor_addr = 0, in one cycle; direction = increment.
  - 00000000: ignored.
- Data write (rs = 1):
  - Addr 0x00..0x0F writes line 1 position addr.
  - Addr 0x40..0x4F writes line 2 position addr - 0x40.
  - Any other address: write dropped silently; cursor still moves.
- Cursor movement, two-line HD44780 map:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00, otherwise +1.
  - Decrement: 0x40 -> 0x27, 0x00 -> 0x67, otherwise -1.
  - A Set DDRAM address in the range 0x28..0x3F or 0x68..0x7F is held as-is. The next increment from it goes +1 until reaching a mapped boundary; 0x7F increments to 0x00.
- Simultaneous edge and reset: reset wins.

Test Plan:
- Reset then init nibbles 3,3,3,2 (rs = 0) -> no byte_valid, no proto_err; mode NIB_HI; both lines = 16 x 8'h20.
- After init, send 0x80 then data 0x41, 0x42 (4 edges each byte pair) -> first_line[127:112] = 16'h4142, cursor_addr = 0x02, byte_valid pulses 3 times, 4 clk after each second lcd_e fall.
- Send 0xC0 then data 0x5A -> second_line[127:120] = 8'h5A, cursor_addr = 0x41. Then 0x8F, data 0x31, 0x32 -> first_line[7:0] = 8'h31, cursor_addr = 0x11; 0x32 dropped from both lines.
- Set cursor 0x27, write data -> cursor_addr = 0x40. Send 0x04 (decrement), write data -> cursor_addr = 0x27. Send 0x80, write data -> cursor_addr = 0x67.
- High nibble with rs = 1, low nibble with rs = 0 -> proto_err pulse, no buffer change; next correct byte accepted normally. Edges with lcd_rw = 1 -> no effect.
- Fill both lines, send 0x01 -> all chars 8'h20, cursor_addr = 0 in the cycle after the edge. Send 0x0C -> disp_on = 1. Assert rst_n = 0 between nibbles -> next nibbles 3,2 required before bytes are accepted.
